priority_rr_arbiter: RTL and testbench

PRIORITY_RR_ARBITER -- requirements
Module: priority_rr_arbiter

---
 rtl/priority_rr_arbiter.sv | 101 ++++++++++
 tb/tb_priority_rr_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/priority_rr_arbiter.sv
// Eight-way round-robin arbiter with a per-owner hold limit. The grant moves directly between
// requesters on release, and every output comes straight from a flop.
module priority_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid
);

    typedef enum logic {StIdle, StGrant} state_e;

    localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] id_q, id_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic [7:0] cand;
    logic [2:0] nxt;

    // Find the first set bit, scanning upward from p and wrapping past 7.
    // The result is only meaningful when v is non-zero.
    function automatic logic [2:0] pick(input logic [7:0] v, input logic [2:0] p);
        logic [2:0] idx;
        pick = p;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (v[idx]) pick = idx;
        end
    endfunction

    assign cand = req & ~(8'b1 << id_q);
    assign nxt  = id_q + 3'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        hold_d  = hold_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                hold_d = 8'd0;
                if (req != 8'd0) begin
                    state_d = StGrant;
                    id_d    = pick(req, ptr_q);
                    valid_d = 1'b1;
                end else begin
                    id_d    = 3'd0;
                    valid_d = 1'b0;
                end
            end
            StGrant: begin
                if (req[id_q] && (hold_q < HoldLast)) begin
                    hold_d = hold_q + 8'd1;
                end else begin
                    ptr_d  = nxt;
                    hold_d = 8'd0;
                    if (cand != 8'd0) begin
                        id_d = pick(cand, nxt);
                    end else if (!req[id_q]) begin
                        state_d = StIdle;
                        id_d    = 3'd0;
                        valid_d = 1'b0;
                    end
                    // Forced release with no other requester: owner is re-granted in place.
                end
            end
        endcase
        gnt_d = valid_d ? (8'b1 << id_d) : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 3'd0;
            id_q    <= 3'd0;
            hold_q  <= 8'd0;
            gnt_q   <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = id_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_priority_rr_arbiter.sv
// Directed and randomized checks for priority_rr_arbiter with MAX_HOLD=4.
module tb_priority_rr_arbiter;

    localparam int unsigned MaxHold = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;

    int checks = 0;
    int errors = 0;

    priority_rr_arbiter #(
        .MAX_HOLD(MaxHold)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .gnt_valid(gnt_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] idx_of(input logic [7:0] v);
        idx_of = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) idx_of = 3'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] eg);
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_id"}, 32'(gnt_id), 32'(idx_of(eg)));
        chk({tag, "_valid"}, 32'(gnt_valid), 32'(eg != 8'd0));
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    int         wait_c [8];
    int         run;
    logic [2:0] prev_id;
    logic       prev_valid;
    logic [7:0] r;

    initial begin
        rst = 1'b1;
        req = 8'd0;
        cyc();
        cyc();
        chk_out("reset", 8'h00);

        rst = 1'b0;
        req = 8'hA4;
        cyc(); chk_out("first_grant", 8'h04);
        req = 8'hA0;
        cyc(); chk_out("move_to_5", 8'h20);
        req = 8'h80;
        cyc(); chk_out("move_to_7", 8'h80);
        req = 8'h00;
        cyc(); chk_out("idle_return", 8'h00);

        // Two requesters alternate every MaxHold cycles
        req = 8'h09;
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk_out("hold_alt", ((i / 4) % 2 == 0) ? 8'h01 : 8'h08);
        end
        req = 8'h00;
        cyc(); chk_out("idle2", 8'h00);

        // Lone requester keeps the grant with no gap across forced releases
        req = 8'h40;
        for (int i = 0; i < 11; i++) begin
            cyc();
            chk_out("solo_hold", 8'h40);
        end
        req = 8'hC1;
        cyc(); chk_out("late_req_ignored", 8'h40);
        cyc(); chk_out("forced_move", 8'h80);
        req = 8'h00;
        cyc(); chk_out("idle3", 8'h00);

        // Move pointer to 3, then reset mid-grant and confirm pointer is back at 0
        req = 8'h04;
        cyc(); chk_out("pre_rst_a", 8'h04);
        req = 8'h08;
        cyc(); chk_out("pre_rst_b", 8'h08);
        rst = 1'b1;
        req = 8'h09;
        cyc(); chk_out("rst_mid", 8'h00);
        rst = 1'b0;
        cyc(); chk_out("post_rst", 8'h01);

        req = 8'h00;
        cyc();
        cyc();
        chk_out("idle4", 8'h00);

        for (int i = 0; i < 8; i++) wait_c[i] = 0;
        run        = 0;
        prev_id    = 3'd0;
        prev_valid = 1'b0;
        r          = 8'h00;
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 8; b++) if ($urandom_range(15) == 0) r[b] = ~r[b];
            req = r;
            cyc();
            chk("rnd_onehot", 32'($onehot0(gnt)), 32'd1);
            chk("rnd_valid", 32'(gnt_valid), 32'(gnt != 8'd0));
            chk("rnd_id", 32'(gnt_id), 32'(idx_of(gnt)));
            if (gnt_valid && prev_valid && (gnt_id == prev_id)) run++;
            else run = gnt_valid ? 1 : 0;
            if (run == MaxHold + 1) begin
                chk("rnd_hold_limit", 32'(req & ~(8'b1 << gnt_id)), 32'd0);
                run = 1;
            end
            for (int b = 0; b < 8; b++) begin
                if (req[b] && !gnt[b]) wait_c[b]++;
                else wait_c[b] = 0;
                chk("rnd_starve", 32'(wait_c[b] <= 8 * MaxHold), 32'd1);
            end
            prev_id    = gnt_id;
            prev_valid = gnt_valid;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
